// File: rtl/hdlc_rx_arb.sv
// hdlc_rx_arb: two-channel HDLC frame buffer with round-robin AXI-Stream merge
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   chN_tvalid/tdata/tlast        hdlc_rx byte stream of channel N (no backpressure)
//   chN_finish                    hdlc_rx idle/abort pulse; rolls back an open frame
//   m_tvalid/tready/tdata/tlast   merged AXI-Stream master, one whole frame per grant
//   m_tuser                       source channel of the frame being streamed
//   drop[N]                       one-cycle pulse when channel N discards a frame
module hdlc_rx_arb #(
  parameter int FIFO_AW = 9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ch0_tvalid,
  input  logic [7:0] ch0_tdata,
  input  logic       ch0_tlast,
  input  logic       ch0_finish,
  input  logic       ch1_tvalid,
  input  logic [7:0] ch1_tdata,
  input  logic       ch1_tlast,
  input  logic       ch1_finish,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic [7:0] m_tdata,
  output logic       m_tlast,
  output logic       m_tuser,
  output logic [1:0] drop
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_LVL = {1'b1, {FIFO_AW{1'b0}}};
  typedef enum logic {IDLE, STREAM} state_t;
  logic [1:0] tv, tl, fin;
  logic [1:0][7:0] td;
  logic [1:0][FIFO_AW:0] cmt, rp;
  logic [1:0][8:0] rdd;
  assign tv = {ch1_tvalid, ch0_tvalid};
  assign tl = {ch1_tlast, ch0_tlast};
  assign fin = {ch1_finish, ch0_finish};
  assign td = {ch1_tdata, ch0_tdata};
  for (genvar c = 0; c < 2; c++) begin : g_ch
    logic [8:0] mem [DEPTH];
    logic [FIFO_AW:0] wp, wc;
    logic [FIFO_AW-1:0] wa;
    logic [7:0] hold;
    logic tl_q, disc, drp, close, open, full, ovf, rb, we;
    // Bytes are written as soon as they arrive; the copy in hold lets a late
    // close rewrite the newest entry with last=1, so one write port suffices.
    assign close = tl[c] & ~tl_q;
    assign open = wp != wc;
    assign full = (wp - rp[c]) == FULL_LVL;
    assign ovf = ~disc & tv[c] & full;
    assign rb = ~disc & ~ovf & fin[c] & ~close & (open | tv[c]);
    assign we = ~disc & ~ovf & ~rb & (tv[c] | (close & open));
    assign wa = tv[c] ? wp[FIFO_AW-1:0] : wp[FIFO_AW-1:0] - 1'b1;
    assign cmt[c] = wc;
    assign rdd[c] = mem[rp[c][FIFO_AW-1:0]];
    assign drop[c] = drp;
    always_ff @(posedge clk)
      if (we) mem[wa] <= {~tv[c] | close, tv[c] ? td[c] : hold};
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        wp <= '0;
        wc <= '0;
        hold <= '0;
        tl_q <= 1'b0;
        disc <= 1'b0;
        drp <= 1'b0;
      end else begin
        tl_q <= tl[c];
        drp <= ovf | rb;
        if (disc) disc <= ~(close | fin[c]);
        else if (ovf) begin
          wp <= wc;
          disc <= ~(close | fin[c]);
        end else if (rb) wp <= wc;
        else if (tv[c]) begin
          hold <= td[c];
          wp <= wp + 1'b1;
          if (close) wc <= wp + 1'b1;
        end else if (close & open) wc <= wp;
      end
  end
  state_t state;
  logic gnt, rr, fetched, pick;
  logic [1:0] elig;
  logic [8:0] rd;
  assign elig = {cmt[1] != rp[1], cmt[0] != rp[0]};
  assign pick = elig[rr] ? rr : ~rr;
  assign rd = rdd[gnt];
  assign m_tuser = gnt;
  // fetched marks that the frame's last byte is already in the output stage,
  // so the read pointer never runs past the committed frame.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      gnt <= 1'b0;
      rr <= 1'b0;
      fetched <= 1'b0;
      rp <= '0;
      m_tvalid <= 1'b0;
      m_tdata <= '0;
      m_tlast <= 1'b0;
    end else if (state == IDLE) begin
      if (|elig) begin
        state <= STREAM;
        gnt <= pick;
        fetched <= 1'b0;
      end
    end else if (~fetched & (~m_tvalid | m_tready)) begin
      m_tvalid <= 1'b1;
      {m_tlast, m_tdata} <= rd;
      rp[gnt] <= rp[gnt] + 1'b1;
      fetched <= rd[8];
    end else if (m_tvalid & m_tready) begin
      m_tvalid <= 1'b0;
      m_tlast <= 1'b0;
      rr <= ~gnt;
      state <= IDLE;
    end
endmodule

// File: tb/tb_hdlc_rx_arb.sv
// tb_hdlc_rx_arb: directed scoreboard bench for hdlc_rx_arb
module tb_hdlc_rx_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic ch0_tvalid = 1'b0, ch0_tlast = 1'b0, ch0_finish = 1'b0;
  logic ch1_tvalid = 1'b0, ch1_tlast = 1'b0, ch1_finish = 1'b0;
  logic [7:0] ch0_tdata = '0, ch1_tdata = '0;
  logic m_tvalid, m_tready = 1'b1, m_tlast, m_tuser;
  logic [7:0] m_tdata;
  logic [1:0] drop;
  int checks = 0, errs = 0, dcnt0 = 0, dcnt1 = 0;
  bit tog = 1'b0;
  logic [9:0] sb[$];
  logic [7:0] fq0[$], fq1[$];
  always #5 clk = ~clk;
  hdlc_rx_arb #(.FIFO_AW(4)) dut (
    .clk(clk), .rst(rst),
    .ch0_tvalid(ch0_tvalid), .ch0_tdata(ch0_tdata), .ch0_tlast(ch0_tlast), .ch0_finish(ch0_finish),
    .ch1_tvalid(ch1_tvalid), .ch1_tdata(ch1_tdata), .ch1_tlast(ch1_tlast), .ch1_finish(ch1_finish),
    .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata), .m_tlast(m_tlast),
    .m_tuser(m_tuser), .drop(drop)
  );
  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    checks++;
    if (a !== e) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic drv(input bit ch, input logic v, input logic [7:0] d, input logic l, input logic f);
    if (ch) begin
      ch1_tvalid = v; ch1_tdata = d; ch1_tlast = l; ch1_finish = f;
    end else begin
      ch0_tvalid = v; ch0_tdata = d; ch0_tlast = l; ch0_finish = f;
    end
  endtask
  // mode 0: tlast with last byte; mode>0: tlast rises mode clk later, held hold clk; mode<0: finish
  task automatic send(input bit ch, input int mode, input int hold);
    logic [7:0] b[$];
    if (ch) b = fq1; else b = fq0;
    foreach (b[i]) begin
      drv(ch, 1'b1, b[i], mode == 0 && i == b.size() - 1, 1'b0);
      step();
    end
    drv(ch, 1'b0, 8'h00, 1'b0, 1'b0);
    if (mode > 0) begin
      repeat (mode - 1) step();
      drv(ch, 1'b0, 8'h00, 1'b1, 1'b0);
      repeat (hold) step();
      drv(ch, 1'b0, 8'h00, 1'b0, 1'b0);
    end else if (mode < 0) begin
      drv(ch, 1'b0, 8'h00, 1'b0, 1'b1);
      step();
      drv(ch, 1'b0, 8'h00, 1'b0, 1'b0);
    end
  endtask
  task automatic expect_frame(input bit ch);
    logic [7:0] b[$];
    if (ch) b = fq1; else b = fq0;
    foreach (b[i]) sb.push_back({ch, i == b.size() - 1, b[i]});
  endtask
  task automatic drain(input string n);
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      step();
      k++;
    end
    chk(n, 16'(sb.size()), 16'd0);
    repeat (5) step();
  endtask
  task automatic rchk(input string n);
    chk({n, " m_tvalid"}, 16'(m_tvalid), 16'd0);
    chk({n, " m_tdata"}, 16'(m_tdata), 16'd0);
    chk({n, " m_tlast"}, 16'(m_tlast), 16'd0);
    chk({n, " m_tuser"}, 16'(m_tuser), 16'd0);
    chk({n, " drop"}, 16'(drop), 16'd0);
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    m_tready = tog ? ~m_tready : 1'b1;
  end
  initial begin
    logic [10:0] prev;
    bit pstall;
    prev = '0;
    pstall = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) pstall = 1'b0;
      else begin
        if (pstall) chk("stable", 16'({m_tvalid, m_tuser, m_tlast, m_tdata}), 16'(prev));
        if (drop[0]) dcnt0++;
        if (drop[1]) dcnt1++;
        if (m_tvalid & m_tready) begin
          if (sb.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected beat: got %h with empty scoreboard", {m_tuser, m_tlast, m_tdata});
          end else chk("beat", 16'({m_tuser, m_tlast, m_tdata}), 16'(sb.pop_front()));
        end
        pstall = m_tvalid & ~m_tready;
        prev = {m_tvalid, m_tuser, m_tlast, m_tdata};
      end
    end
  end
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int k;
    repeat (2) step();
    rchk("reset");
    rst = 1'b0;
    step();
    fq0 = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
    expect_frame(1'b0);
    send(1'b0, 0, 0);
    @(negedge clk);
    chk("t1 latency commit", 16'(m_tvalid), 16'd0);
    @(negedge clk);
    chk("t1 latency grant", 16'(m_tvalid), 16'd0);
    @(negedge clk);
    chk("t1 latency first", 16'(m_tvalid), 16'd1);
    drain("t1 drain");
    fq1 = {8'hAA, 8'hBB, 8'hCC};
    expect_frame(1'b1);
    send(1'b1, 3, 13);
    drain("t2 drain");
    tog = 1'b1;
    fq0 = {8'h10, 8'h11, 8'h12};
    fq1 = {8'h20, 8'h21, 8'h22, 8'h23};
    for (int r = 0; r < 2; r++) begin
      expect_frame(1'b0);
      expect_frame(1'b1);
      fork
        send(1'b1, 0, 0);
        begin
          step();
          send(1'b0, 0, 0);
        end
      join
      drain("t3 drain");
    end
    tog = 1'b0;
    fq0 = {};
    for (int i = 0; i < 20; i++) fq0.push_back(8'(i));
    send(1'b0, 0, 0);
    step();
    chk("t4 drop0", 16'(dcnt0), 16'd1);
    drain("t4 no output");
    fq0 = {8'h7E, 8'h01, 8'h02};
    expect_frame(1'b0);
    send(1'b0, 0, 0);
    drain("t4 next frame");
    fq1 = {8'h91, 8'h92, 8'h93, 8'h94};
    send(1'b1, -1, 0);
    step();
    chk("t5 drop1", 16'(dcnt1), 16'd1);
    drain("t5 no output");
    fq1 = {8'h33, 8'h44};
    expect_frame(1'b1);
    send(1'b1, 0, 0);
    drain("t5 next frame");
    fq0 = {8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    expect_frame(1'b0);
    send(1'b0, 0, 0);
    k = 0;
    while (!m_tvalid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("t6 streaming", 16'(m_tvalid), 16'd1);
    #2;
    rst = 1'b1;
    #1;
    rchk("t6 async reset");
    sb.delete();
    repeat (2) step();
    rst = 1'b0;
    repeat (10) step();
    chk("t6 fifos empty", 16'(m_tvalid), 16'd0);
    fq0 = {8'hC3, 8'h3C};
    expect_frame(1'b0);
    send(1'b0, 0, 0);
    drain("t6 after reset");
    chk("total drop0", 16'(dcnt0), 16'd1);
    chk("total drop1", 16'(dcnt1), 16'd1);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
